// File: rtl/issueq_req_ctrl.sv
// Requester side of the 32-entry issue-queue select tree: tracks per-entry
// valid/operand readiness, allocates on dispatch, applies wakeups, retires grants.
module issueq_req_ctrl #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             disp_vld_i,
  output logic             disp_rdy_o,
  input  logic [TAG_W-1:0] disp_src0_tag_i,
  input  logic             disp_src0_rdy_i,
  input  logic [TAG_W-1:0] disp_src1_tag_i,
  input  logic             disp_src1_rdy_i,
  output logic [IDX_W-1:0] disp_idx_o,
  input  logic             wake0_vld_i,
  input  logic [TAG_W-1:0] wake0_tag_i,
  input  logic             wake1_vld_i,
  input  logic [TAG_W-1:0] wake1_tag_i,
  output logic [DEPTH-1:0] req_vec_o,
  input  logic             grant_vld_i,
  input  logic [IDX_W-1:0] grant_idx_i,
  output logic [IDX_W:0]   free_cnt_o,
  output logic             grant_err_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] src0_rdy_q;
  logic [DEPTH-1:0] src1_rdy_q;
  logic [TAG_W-1:0] src0_tag_q [DEPTH];
  logic [TAG_W-1:0] src1_tag_q [DEPTH];
  logic [IDX_W:0]   free_cnt_q;
  logic             grant_err_q;

  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_found;
  logic [DEPTH-1:0] wake_src0;
  logic [DEPTH-1:0] wake_src1;
  logic             disp_src0_rdy;
  logic             disp_src1_rdy;
  logic             disp_acc;
  logic             grant_hit;

  assign req_vec_o   = valid_q & src0_rdy_q & src1_rdy_q;
  assign disp_rdy_o  = (free_cnt_q != '0);
  assign disp_idx_o  = alloc_idx;
  assign free_cnt_o  = free_cnt_q;
  assign grant_err_o = grant_err_q;

  assign disp_acc  = disp_vld_i & disp_rdy_o & ~flush_i;
  assign grant_hit = grant_vld_i & req_vec_o[grant_idx_i];

  // Lowest-index free entry, taken from pre-edge state so a same-cycle grant
  // never hands its slot to the concurrent dispatch.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    wake_src0 = '0;
    wake_src1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake_src0[i] = (wake0_vld_i && wake0_tag_i == src0_tag_q[i]) ||
                     (wake1_vld_i && wake1_tag_i == src0_tag_q[i]);
      wake_src1[i] = (wake0_vld_i && wake0_tag_i == src1_tag_q[i]) ||
                     (wake1_vld_i && wake1_tag_i == src1_tag_q[i]);
    end
    disp_src0_rdy = disp_src0_rdy_i ||
                    (wake0_vld_i && wake0_tag_i == disp_src0_tag_i) ||
                    (wake1_vld_i && wake1_tag_i == disp_src0_tag_i);
    disp_src1_rdy = disp_src1_rdy_i ||
                    (wake0_vld_i && wake0_tag_i == disp_src1_tag_i) ||
                    (wake1_vld_i && wake1_tag_i == disp_src1_tag_i);
  end

  // Grant clears after wakeup so a wakeup landing on a retiring entry is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      src0_rdy_q  <= '0;
      src1_rdy_q  <= '0;
      free_cnt_q  <= (IDX_W+1)'(DEPTH);
      grant_err_q <= 1'b0;
    end else if (flush_i) begin
      valid_q     <= '0;
      src0_rdy_q  <= '0;
      src1_rdy_q  <= '0;
      free_cnt_q  <= (IDX_W+1)'(DEPTH);
      grant_err_q <= 1'b0;
    end else begin
      src0_rdy_q <= src0_rdy_q | (valid_q & wake_src0);
      src1_rdy_q <= src1_rdy_q | (valid_q & wake_src1);
      if (grant_hit) begin
        valid_q[grant_idx_i]    <= 1'b0;
        src0_rdy_q[grant_idx_i] <= 1'b0;
        src1_rdy_q[grant_idx_i] <= 1'b0;
      end
      if (disp_acc) begin
        valid_q[alloc_idx]    <= 1'b1;
        src0_rdy_q[alloc_idx] <= disp_src0_rdy;
        src1_rdy_q[alloc_idx] <= disp_src1_rdy;
      end
      free_cnt_q  <= free_cnt_q - (IDX_W+1)'(disp_acc) + (IDX_W+1)'(grant_hit);
      grant_err_q <= grant_vld_i & ~req_vec_o[grant_idx_i];
    end
  end

  // Tags need no reset; they are only consulted while the entry is valid.
  always_ff @(posedge clk_i) begin
    if (disp_acc) begin
      src0_tag_q[alloc_idx] <= disp_src0_tag_i;
      src1_tag_q[alloc_idx] <= disp_src1_tag_i;
    end
  end

endmodule

// File: tb/tb_issueq_req_ctrl.sv
// Self-checking bench for issueq_req_ctrl: directed scenarios plus randomized
// traffic compared against an entry-array reference model.
module tb_issueq_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_vld;
  logic        disp_rdy;
  logic [6:0]  disp_src0_tag;
  logic        disp_src0_rdy;
  logic [6:0]  disp_src1_tag;
  logic        disp_src1_rdy;
  logic [4:0]  disp_idx;
  logic        wake0_vld;
  logic [6:0]  wake0_tag;
  logic        wake1_vld;
  logic [6:0]  wake1_tag;
  logic [31:0] req_vec;
  logic        grant_vld;
  logic [4:0]  grant_idx;
  logic [5:0]  free_cnt;
  logic        grant_err;

  int n_cmp = 0;
  int n_err = 0;

  bit       m_valid [32];
  bit       m_rdy0  [32];
  bit       m_rdy1  [32];
  bit [6:0] m_tag0  [32];
  bit [6:0] m_tag1  [32];
  bit       m_err;

  issueq_req_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .disp_vld_i(disp_vld), .disp_rdy_o(disp_rdy),
    .disp_src0_tag_i(disp_src0_tag), .disp_src0_rdy_i(disp_src0_rdy),
    .disp_src1_tag_i(disp_src1_tag), .disp_src1_rdy_i(disp_src1_rdy),
    .disp_idx_o(disp_idx),
    .wake0_vld_i(wake0_vld), .wake0_tag_i(wake0_tag),
    .wake1_vld_i(wake1_vld), .wake1_tag_i(wake1_tag),
    .req_vec_o(req_vec), .grant_vld_i(grant_vld), .grant_idx_i(grant_idx),
    .free_cnt_o(free_cnt), .grant_err_o(grant_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < 32; i++) if (!m_valid[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_req();
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r[i] = m_valid[i] && m_rdy0[i] && m_rdy1[i];
    return r;
  endfunction

  function automatic int model_lowest_free();
    for (int i = 0; i < 32; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic bit broadcast_hits(input bit [6:0] t);
    return (wake0_vld && wake0_tag == t) || (wake1_vld && wake1_tag == t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0; m_rdy0[i] = 0; m_rdy1[i] = 0;
    end
    m_err = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit [31:0] req_now;
    int        slot;
    bit        accept;
    bit        hit;
    req_now = model_req();
    if (flush) begin
      model_reset();
      return;
    end
    slot   = model_lowest_free();
    accept = disp_vld && (model_free() > 0);
    hit    = grant_vld && req_now[grant_idx];
    m_err  = grant_vld && !hit;
    for (int i = 0; i < 32; i++) begin
      if (m_valid[i]) begin
        if (broadcast_hits(m_tag0[i])) m_rdy0[i] = 1;
        if (broadcast_hits(m_tag1[i])) m_rdy1[i] = 1;
      end
    end
    if (hit) begin
      m_valid[grant_idx] = 0; m_rdy0[grant_idx] = 0; m_rdy1[grant_idx] = 0;
    end
    if (accept) begin
      m_valid[slot] = 1;
      m_tag0[slot]  = disp_src0_tag;
      m_tag1[slot]  = disp_src1_tag;
      m_rdy0[slot]  = disp_src0_rdy || broadcast_hits(disp_src0_tag);
      m_rdy1[slot]  = disp_src1_rdy || broadcast_hits(disp_src1_tag);
    end
  endtask

  task automatic apply_stimulus(input bit dv, input bit [6:0] t0, input bit r0,
                                input bit [6:0] t1, input bit r1,
                                input bit w0v, input bit [6:0] w0t,
                                input bit w1v, input bit [6:0] w1t,
                                input bit gv, input bit [4:0] gi, input bit fl);
    disp_vld = dv; disp_src0_tag = t0; disp_src0_rdy = r0;
    disp_src1_tag = t1; disp_src1_rdy = r1;
    wake0_vld = w0v; wake0_tag = w0t; wake1_vld = w1v; wake1_tag = w1t;
    grant_vld = gv; grant_idx = gi; flush = fl;
    #1;
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare all outputs with the model, then clock both and return at negedge.
  task automatic step();
    check_output("req_vec", req_vec, model_req());
    check_output("free_cnt", free_cnt, model_free());
    check_output("disp_rdy", disp_rdy, model_free() > 0);
    check_output("grant_err", grant_err, m_err);
    if (model_free() > 0) check_output("disp_idx", disp_idx, model_lowest_free());
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    bit [31:0] rq;
    int        cands [$];
    rst_n = 1'b0;
    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("reset_free", free_cnt, 32);
    check_output("reset_req", req_vec, 0);
    check_output("reset_rdy", disp_rdy, 1);
    check_output("reset_idx", disp_idx, 0);
    check_output("reset_err", grant_err, 0);

    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1, 7'(i), 1, 7'(i + 40), 1, 0, 0, 0, 0, 0, 0, 0);
      check_output("fill_idx", disp_idx, i);
      step();
    end
    idle();
    check_output("full_req", req_vec, 32'hFFFF_FFFF);
    check_output("full_free", free_cnt, 0);
    check_output("full_rdy", disp_rdy, 0);
    apply_stimulus(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    check_output("drop_free", free_cnt, 0);

    apply_stimulus(1, 2, 1, 2, 1, 0, 0, 0, 0, 1, 5, 0);
    check_output("grant_full_rdy", disp_rdy, 0);
    step();
    idle();
    check_output("after_grant_free", free_cnt, 1);
    check_output("after_grant_idx", disp_idx, 5);
    apply_stimulus(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    check_output("refill_free", free_cnt, 0);
    check_output("refill_req5", req_vec[5], 1);

    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    apply_stimulus(1, 7'h12, 0, 7'h05, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 1, 7'h12, 0, 0, 0, 0, 0);
    check_output("wake_before_req0", req_vec[0], 0);
    step();
    idle();
    check_output("wake_after_req0", req_vec[0], 1);

    apply_stimulus(1, 7'h01, 1, 7'h33, 0, 0, 0, 1, 7'h33, 0, 0, 0);
    check_output("sameclk_idx", disp_idx, 1);
    step();
    idle();
    check_output("sameclk_req1", req_vec[1], 1);

    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step();
    idle();
    check_output("gerr_pulse", grant_err, 1);
    check_output("gerr_free", free_cnt, 30);
    step();
    check_output("gerr_clear", grant_err, 0);

    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1, 7'(i), 1, 7'(i), 1, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    apply_stimulus(1, 9, 1, 9, 1, 1, 9, 1, 9, 1, 3, 1);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 1);
    check_output("flush_req", req_vec, 0);
    check_output("flush_free", free_cnt, 32);
    check_output("flush_err", grant_err, 0);
    step();
    idle();
    check_output("flush_noerr", grant_err, 0);

    for (int c = 0; c < 3000; c++) begin
      rq = model_req();
      cands.delete();
      for (int i = 0; i < 32; i++) if (rq[i]) cands.push_back(i);
      apply_stimulus($urandom_range(0, 9) < 6, 7'($urandom_range(0, 15)), $urandom_range(0, 9) < 3,
                     7'($urandom_range(0, 15)), $urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) < 3, 7'($urandom_range(0, 15)),
                     $urandom_range(0, 9) < 3, 7'($urandom_range(0, 15)),
                     $urandom_range(0, 9) < 5,
                     (cands.size() > 0 && $urandom_range(0, 9) < 7) ?
                       5'(cands[$urandom_range(0, cands.size() - 1)]) : 5'($urandom_range(0, 31)),
                     $urandom_range(0, 99) < 2);
      step();
    end

    apply_stimulus(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    apply_stimulus(1, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check_output("async_free", free_cnt, 32);
    check_output("async_req", req_vec, 0);
    check_output("async_rdy", disp_rdy, 1);
    check_output("async_idx", disp_idx, 0);
    check_output("async_err", grant_err, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issueq_req_ctrl.md
Name: issueq_req_ctrl

Overview:
- Requester side of the 32-entry issue-queue select tree.
- Tracks per-entry valid and source-operand readiness, allocates entries on dispatch, and applies tag-broadcast wakeups.
- Drives the 32-bit request vector into the select tree and retires the entry named by the returned grant index.
- Sits between rename/dispatch and the select tree; the select tree itself and entry payload RAM are outside this block.

Parameters:
DEPTH, 32, number of queue entries (fixed 32 to match select tree)
IDX_W, 5, entry index width (log2 DEPTH)
TAG_W, 7, physical register tag width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; invalidates all entries
disp_vld_i  in  1  dispatch request, one instruction per cycle
disp_rdy_o  out  1  a free entry exists (free_cnt_o != 0)
disp_src0_tag_i  in  TAG_W  source 0 physical tag
disp_src0_rdy_i  in  1  source 0 already available at dispatch
disp_src1_tag_i  in  TAG_W  source 1 physical tag
disp_src1_rdy_i  in  1  source 1 already available at dispatch
disp_idx_o  out  IDX_W  entry allocated to the current dispatch (valid when disp_vld_i & disp_rdy_o)
wake0_vld_i  in  1  wakeup port 0 valid
wake0_tag_i  in  TAG_W  wakeup port 0 tag
wake1_vld_i  in  1  wakeup port 1 valid
wake1_tag_i  in  TAG_W  wakeup port 1 tag
req_vec_o  out  DEPTH  per-entry issue request to select tree
grant_vld_i  in  1  select tree grant valid
grant_idx_i  in  IDX_W  granted entry index
free_cnt_o  out  IDX_W+1  number of free entries (0..32)
grant_err_o  out  1  registered pulse: grant hit a non-requesting entry

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low, rst_ni.
- State per entry: valid, src0_rdy, src1_rdy, src0_tag, src1_tag.
- Reset values: all valid=0, all rdy=0, free_cnt_o=32, grant_err_o=0, req_vec_o=0, disp_rdy_o=1, disp_idx_o=0. Tags are don't-care.
- req_vec_o[i] = valid[i] & src0_rdy[i] & src1_rdy[i]. Combinational from registers only; no input-to-req_vec_o path.
- Allocation:
  - disp_idx_o = lowest-index entry with valid=0, computed from current-cycle state.
  - On disp_vld_i & disp_rdy_o & !flush_i, that entry is written at the clock edge.
  - disp_vld_i while disp_rdy_o=0 is dropped; no state change.
- Dispatch-time wakeup:
  - Written src rdy = disp_srcN_rdy_i | (wake0_vld_i & wake0_tag_i==disp_srcN_tag_i) | (wake1 equivalent).
  - A same-cycle broadcast is never missed.
- Entry wakeup: each cycle, every valid entry with srcN_rdy=0 sets srcN_rdy=1 if either valid wake port tag matches srcN_tag. Visible on req_vec_o next cycle.
- Grant:
  - grant_vld_i with req_vec_o[grant_idx_i]=1 clears valid and both rdy bits of that entry at the edge.
  - grant_vld_i with req_vec_o[grant_idx_i]=0 changes no state, and grant_err_o=1 in the next cycle only.
- Dispatch and grant in the same cycle:
  - Allocation uses pre-edge state, so the entry freed this cycle is not reused this cycle.
  - free_cnt_o unchanged net (+1 −1).
- free_cnt_o next = free_cnt_o − (dispatch accepted) + (valid grant). Never below 0 or above 32.
- Flush:
  - flush_i=1 clears all valid and rdy bits at the edge; free_cnt_o=32 next cycle.
  - Dispatch, grant and wakeup in a flush cycle are discarded.
  - grant_err_o is not raised in a flush cycle.
- Reset asserted mid-operation forces reset values immediately (asynchronous), regardless of pending dispatch or grant.
- Latency:
  - Dispatch with both sources ready → req bit high the cycle after dispatch.
  - Wakeup → req bit high the next cycle.
  - Grant → req bit low the next cycle.

Test Plan:
- Reset, then 32 back-to-back dispatches with both sources ready → disp_idx_o 0..31 in order; req_vec_o=0xFFFFFFFF; free_cnt_o=0; disp_rdy_o=0; a 33rd dispatch is dropped.
- Dispatch entry 0 with src0_tag=0x12 not ready, src1 ready; next cycle wake0_vld_i=1, tag 0x12 → req_vec_o[0]=0 until the cycle after the wake, then 1.
- Dispatch with src1_tag=0x33 not ready while wake1 broadcasts 0x33 in the same cycle → req bit set the cycle after dispatch.
- Full queue; grant_idx_i=5 and a dispatch in the same cycle → dispatch dropped (disp_rdy_o=0); next cycle free_cnt_o=1, disp_idx_o=5; dispatch then → entry 5 refilled, free_cnt_o=0.
- Grant idx 9 while entry 9 is invalid → grant_err_o=1 for exactly one cycle; free_cnt_o unchanged.
- Ten valid entries, flush_i=1 with a concurrent dispatch and grant → next cycle req_vec_o=0, free_cnt_o=32, grant_err_o=0. Also assert rst_ni low mid-dispatch → outputs take reset values without waiting for a clock edge.
